chacha20_stream_ctrl: RTL and testbench

CHACHA20_STREAM_CTRL -- requirements
Module: chacha20_stream_ctrl

---
 rtl/chacha20_stream_ctrl.sv | 145 ++++++++++++++
 tb/tb_chacha20_stream_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_stream_ctrl.sv
// ChaCha20 keystream controller: requests cfg_nblk core blocks in sequence and
// serialises each 512-bit block as 16 words on a valid/ready stream.
module chacha20_stream_ctrl #(
  parameter int unsigned NBLK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [255:0]      cfg_key,
  input  logic [95:0]       cfg_nonce,
  input  logic [31:0]       cfg_counter,
  input  logic [NBLK_W-1:0] cfg_nblk,
  input  logic              abort,
  output logic              core_start,
  output logic [255:0]      core_key,
  output logic [95:0]       core_nonce,
  output logic [31:0]       core_counter,
  input  logic              core_busy,
  input  logic              core_done,
  input  logic [511:0]      core_state,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [31:0]       ks_data,
  output logic              ks_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT, ST_STREAM, ST_FIN, ST_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [95:0]        nonce_q, nonce_d;
  logic [31:0]        ctr_q, ctr_d;
  logic [NBLK_W-1:0]  rem_q, rem_d;
  logic [15:0][31:0]  buf_q, buf_d;
  logic [3:0]         widx_q, widx_d;
  logic               err_q, err_d;
  logic               hs;
  logic               ovf;

  assign cfg_ready = (state_q == ST_IDLE) && !core_busy;
  // Abort takes priority over a simultaneous configuration handshake.
  assign hs  = cfg_valid && cfg_ready && !abort;
  assign ovf = ({1'b0, cfg_counter} + 33'(cfg_nblk) - 33'd1) > 33'h0_FFFF_FFFF;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    widx_d  = widx_q;
    err_d   = err_q;
    if (abort && state_q != ST_IDLE) begin
      state_d = core_busy ? ST_DRAIN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hs) begin
            key_d   = cfg_key;
            nonce_d = cfg_nonce;
            ctr_d   = cfg_counter;
            rem_d   = cfg_nblk;
            widx_d  = '0;
            err_d   = 1'b0;
            if (cfg_nblk == '0) begin
              state_d = ST_FIN;
            end else if (ovf) begin
              err_d   = 1'b1;
              state_d = ST_FIN;
            end else begin
              state_d = ST_START;
            end
          end
        end
        ST_START: state_d = ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            buf_d   = core_state;
            widx_d  = '0;
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (ks_ready) begin
            widx_d = widx_q + 4'd1;
            if (widx_q == 4'd15) begin
              if (rem_q == NBLK_W'(1)) begin
                state_d = ST_FIN;
              end else begin
                ctr_d   = ctr_q + 32'd1;
                rem_d   = rem_q - NBLK_W'(1);
                state_d = ST_START;
              end
            end
          end
        end
        ST_FIN:   state_d = ST_IDLE;
        ST_DRAIN: if (!core_busy) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      widx_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      widx_q  <= widx_d;
      err_q   <= err_d;
    end
  end

  // Word 0 sits in the top 32 bits of the captured block.
  assign ks_data      = buf_q[4'd15 - widx_q];
  assign ks_valid     = (state_q == ST_STREAM);
  assign ks_last      = ks_valid && (widx_q == 4'd15) && (rem_q == NBLK_W'(1));
  assign core_start   = (state_q == ST_START);
  assign core_key     = key_q;
  assign core_nonce   = nonce_q;
  assign core_counter = ctr_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN) && !abort;
  assign err          = err_q;

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Bench for chacha20_stream_ctrl: behavioural ChaCha20 core model, queue
// scoreboard for keystream words and core counters, randomized backpressure.
module tb_chacha20_stream_ctrl;
  localparam int unsigned NBLK_W = 16;
  localparam logic [255:0] RFC_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  RFC_NONCE = 96'h000000090000004a00000000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [255:0] cfg_key = '0;
  logic [95:0] cfg_nonce = '0;
  logic [31:0] cfg_counter = '0;
  logic [NBLK_W-1:0] cfg_nblk = '0;
  logic abort = 1'b0;
  logic core_start;
  logic [255:0] core_key;
  logic [95:0] core_nonce;
  logic [31:0] core_counter;
  logic core_busy = 1'b0;
  logic core_done = 1'b0;
  logic [511:0] core_state = '0;
  logic ks_valid;
  logic ks_ready = 1'b1;
  logic [31:0] ks_data;
  logic ks_last;
  logic busy, done, err;

  always #5 clk = ~clk;

  chacha20_stream_ctrl #(.NBLK_W(NBLK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key),
    .cfg_nonce(cfg_nonce), .cfg_counter(cfg_counter), .cfg_nblk(cfg_nblk),
    .abort(abort),
    .core_start(core_start), .core_key(core_key), .core_nonce(core_nonce),
    .core_counter(core_counter), .core_busy(core_busy), .core_done(core_done),
    .core_state(core_state),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_last(ks_last),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  int unsigned total = 0;
  int unsigned bad = 0;
  word_t       exp_q[$];
  word_t       got_q[$];
  logic [31:0] ctr_exp_q[$];
  int unsigned done_cnt = 0;
  int unsigned start_cnt = 0;
  int unsigned valid_cnt = 0;
  bit          rdy_rand = 1'b0;
  bit          rdy_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Byte strings are MSB-first; ChaCha words are little-endian over those bytes.
  function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [95:0] n,
                                                input logic [31:0] c);
    logic [31:0] s[16];
    logic [31:0] x[16];
    int unsigned qi[8][4];
    int unsigned a, b, cc, d;
    logic [511:0] blk;
    qi = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
           '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = bswap(n[95-32*i -: 32]);
    x = s;
    for (int r = 0; r < 10; r++) begin
      for (int q = 0; q < 8; q++) begin
        a = qi[q][0]; b = qi[q][1]; cc = qi[q][2]; d = qi[q][3];
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
      end
    end
    for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = x[i] + s[i];
    return blk;
  endfunction

  // Core model: fixed-function block generator with random latency.
  logic [255:0] cm_key;
  logic [95:0]  cm_nonce;
  logic [31:0]  cm_ctr;
  logic [511:0] cm_res;
  int unsigned  cm_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy  <= 1'b0;
      core_done  <= 1'b0;
      core_state <= '0;
      cm_cnt     <= 0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        start_cnt++;
        if (ctr_exp_q.size() == 0) check("unexpected_core_start", 1, 0);
        else check("core_counter_at_start", core_counter, ctr_exp_q.pop_front());
        cm_key    <= core_key;
        cm_nonce  <= core_nonce;
        cm_ctr    <= core_counter;
        cm_res    <= chacha_block(core_key, core_nonce, core_counter);
        cm_cnt    <= $urandom_range(2, 6);
        core_busy <= 1'b1;
      end else if (core_busy) begin
        check("core_inputs_stable", {61'd0, core_key == cm_key, core_nonce == cm_nonce,
              core_counter == cm_ctr}, 64'd7);
        if (cm_cnt == 0) begin
          core_busy  <= 1'b0;
          core_done  <= 1'b1;
          core_state <= cm_res;
        end else begin
          cm_cnt <= cm_cnt - 1;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    ks_ready = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: pops the scoreboard on every accepted word.
  bit          prev_stall = 1'b0;
  bit          prev_last_hs = 1'b0;
  bit          prev_done = 1'b0;
  logic [31:0] prev_data;
  word_t       w;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0; prev_last_hs = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", ks_valid, 1);
        check("stall_data_held", ks_data, prev_data);
      end
      if (prev_last_hs) check("done_after_last", done, 1);
      if (done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 0);
      end
      if (ks_valid) valid_cnt++;
      prev_last_hs = 1'b0;
      if (ks_valid && ks_ready && !abort) begin
        w.data = ks_data;
        w.last = ks_last;
        got_q.push_back(w);
        if (exp_q.size() == 0) begin
          check("unexpected_word", {32'd0, ks_data}, 64'hDEAD_0000_0000);
        end else begin
          w = exp_q.pop_front();
          check("ks_data", ks_data, w.data);
          check("ks_last", ks_last, w.last);
          prev_last_hs = w.last;
        end
      end
      prev_stall = ks_valid && !ks_ready && !abort;
      prev_data  = ks_data;
      prev_done  = done;
    end
  end

  task automatic issue(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                       input logic [NBLK_W-1:0] nb, output bit exp_err);
    logic [32:0] endc;
    logic [511:0] blk;
    bit ok;
    word_t e;
    endc = {1'b0, c} + 33'(nb) - 33'd1;
    exp_err = (nb != 0) && (endc > 33'h0_FFFF_FFFF);
    got_q.delete();
    if (nb != 0 && !exp_err) begin
      for (int unsigned b = 0; b < nb; b++) begin
        ctr_exp_q.push_back(c + b);
        blk = chacha_block(k, n, c + b);
        for (int j = 0; j < 16; j++) begin
          e.data = blk[511-32*j -: 32];
          e.last = (b == nb - 1) && (j == 15);
          exp_q.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    cfg_key = k; cfg_nonce = n; cfg_counter = c; cfg_nblk = nb; cfg_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("cfg_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned d0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic run_job(input string tag, input logic [255:0] k, input logic [95:0] n,
                         input logic [31:0] c, input logic [NBLK_W-1:0] nb);
    bit e;
    int unsigned d0, s0, v0, nlast, nw;
    d0 = done_cnt; s0 = start_cnt; v0 = valid_cnt;
    issue(k, n, c, nb, e);
    wait_done(tag, d0);
    repeat (3) @(posedge clk);
    #1;
    nw = (e || nb == 0) ? 0 : 16 * nb;
    nlast = 0;
    foreach (got_q[i]) if (got_q[i].last) nlast++;
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_core_starts"}, start_cnt - s0, (e || nb == 0) ? 0 : nb);
    check({tag, "_words"}, got_q.size(), nw);
    check({tag, "_last_count"}, nlast, (nw != 0) ? 1 : 0);
    check({tag, "_scoreboard_empty"}, exp_q.size() + ctr_exp_q.size(), 0);
    check({tag, "_err"}, err, e);
    check({tag, "_busy_idle"}, busy, 0);
    if (nw == 0) check({tag, "_no_ks_valid"}, valid_cnt - v0, 0);
  endtask

  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
    return k;
  endfunction

  function automatic logic [95:0] rnd_nonce();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctrl_outs"}, {58'd0, core_start, ks_valid, ks_last, busy, done, err}, 0);
    check({tag, "_ks_data"}, ks_data, 0);
    check({tag, "_core_regs"}, {31'd0, |core_key, core_counter}, 0);
    check({tag, "_core_nonce"}, {63'd0, |core_nonce}, 0);
  endtask

  task automatic wait_words(input int unsigned nwords);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 2000 && n < nwords; i++) begin
      @(negedge clk);
      if (ks_valid && ks_ready) n++;
    end
    if (n < nwords) check("word_wait_timeout", n, nwords);
  endtask

  initial begin
    bit e;
    int unsigned d0;
    bit ok;
    logic [255:0] k;
    logic [95:0] n;

    #1 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_rand = 1'b0;
    run_job("rfc", RFC_KEY, RFC_NONCE, 32'd1, 16'd1);
    check("rfc_first_word", got_q.size() > 0 ? got_q[0].data : 32'h0, 32'he4e7f110);
    check("rfc_last_on_16", got_q.size() == 16 ? got_q[15].last : 1'b0, 1);

    rdy_rand = 1'b1;
    run_job("backpressure", RFC_KEY, RFC_NONCE, 32'd1, 16'd1);
    check("bp_first_word", got_q.size() > 0 ? got_q[0].data : 32'h0, 32'he4e7f110);

    run_job("multiblock", rnd_key(), rnd_nonce(), 32'd1, 16'd3);

    rdy_rand = 1'b0;
    run_job("nblk0", rnd_key(), rnd_nonce(), $urandom(), 16'd0);
    run_job("overflow", rnd_key(), rnd_nonce(), 32'hFFFF_FFFF, 16'd2);
    repeat (5) @(posedge clk);
    #1 check("overflow_err_held", err, 1);
    run_job("max_counter", rnd_key(), rnd_nonce(), 32'hFFFF_FFFF, 16'd1);

    rdy_rand = 1'b1;
    for (int i = 0; i < 4; i++)
      run_job("random", rnd_key(), rnd_nonce(), $urandom(), NBLK_W'($urandom_range(1, 3)));

    // Abort while word 5 is presented.
    rdy_rand = 1'b0;
    d0 = done_cnt;
    issue(rnd_key(), rnd_nonce(), 32'd7, 16'd2, e);
    wait_words(5);
    @(posedge clk); #1;
    rdy_hold = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_stream_valid_low", ks_valid, 0);
    exp_q.delete(); ctr_exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort_stream_no_done", done_cnt - d0, 0);
    check("abort_stream_idle", {busy, cfg_ready}, 2'b01);
    rdy_hold = 1'b0;
    run_job("after_abort_stream", RFC_KEY, RFC_NONCE, 32'd1, 16'd2);

    // Abort while waiting on the core.
    d0 = done_cnt;
    issue(rnd_key(), rnd_nonce(), 32'd100, 16'd1, e);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_busy) begin ok = 1'b1; break; end
    end
    check("wait_core_busy_seen", ok, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete(); ctr_exp_q.delete();
    @(negedge clk);
    check("abort_wait_valid_low", ks_valid, 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!core_busy) begin ok = 1'b1; break; end
      check("drain_cfg_ready_low", cfg_ready, 0);
      @(negedge clk);
    end
    check("drain_core_idle", ok, 1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_wait_no_done", done_cnt - d0, 0);
    check("abort_wait_ready", {busy, cfg_ready}, 2'b01);
    rdy_rand = 1'b1;
    run_job("after_abort_wait", rnd_key(), rnd_nonce(), $urandom(), 16'd2);

    // Reset mid-stream.
    k = rnd_key(); n = rnd_nonce();
    d0 = done_cnt;
    issue(k, n, 32'd55, 16'd2, e);
    wait_words(7);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    exp_q.delete(); ctr_exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_no_done", done_cnt - d0, 0);
    run_job("after_reset", k, n, 32'd55, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
